// File: rtl/or_nway_acc_pkg.sv
// Shared definitions for the N-way OR reducer/accumulator: FSM state and packet mode encodings.
package or_nway_acc_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  typedef enum logic {
    MODE_BEAT = 1'b0,
    MODE_ACC  = 1'b1
  } mode_t;

endpackage

// File: rtl/or_tree.sv
// Combinational CHANNELS x WIDTH -> WIDTH OR reduction; reusable by other wide-OR blocks.
module or_tree #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 8
) (
  input  logic [CHANNELS*WIDTH-1:0] data,
  output logic [WIDTH-1:0]          result
);

  logic [WIDTH-1:0] chain [0:CHANNELS];

  assign chain[0] = '0;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign chain[c+1] = chain[c] | data[c*WIDTH +: WIDTH];
  end

  assign result = chain[CHANNELS];

endmodule

// File: rtl/or_nway_acc.sv
// Registered N-channel OR reducer with valid/ready handshake and per-beat or packet-accumulate modes.
// Optional beat counter output out_beats_o is enabled by defining OR_BEATCNT_EN.
module or_nway_acc
  import or_nway_acc_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [CHANNELS*WIDTH-1:0] in_data_i,
  input  logic                      in_last_i,
  input  logic                      mode_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [WIDTH-1:0]          out_data_o,
  output logic                      out_any_o
`ifdef OR_BEATCNT_EN
  ,
  output logic [CNT_W-1:0]          out_beats_o
`endif
);

  if (CHANNELS < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("or_nway_acc: CHANNELS and CNT_W must be at least 1");
  end

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] beat;
  logic [WIDTH-1:0] result;
  logic             accept;
  logic             emit;

  or_tree #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_tree (
    .data   (in_data_i),
    .result (beat)
  );

  assign in_ready_o = ~out_valid_o | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;

  // S_ACC is only ever entered in accumulate mode, so the state itself is the latched mode.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    emit    = 1'b0;
    result  = '0;
    if (accept) begin
      unique case (state)
        S_IDLE: begin
          if (mode_i == MODE_BEAT || in_last_i) begin
            emit   = 1'b1;
            result = beat;
          end else begin
            acc_n   = beat;
            state_n = S_ACC;
          end
        end
        S_ACC: begin
          if (in_last_i) begin
            emit    = 1'b1;
            result  = acc | beat;
            acc_n   = '0;
            state_n = S_IDLE;
          end else begin
            acc_n = acc | beat;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_IDLE;
      acc   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
    end
  end

  // A new emit reloads the output in the same cycle the old result is taken: no bubble.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_any_o   <= 1'b0;
    end else if (emit) begin
      out_valid_o <= 1'b1;
      out_data_o  <= result;
      out_any_o   <= |result;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

`ifdef OR_BEATCNT_EN
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] beats_res;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    cnt_n     = cnt;
    beats_res = '0;
    if (accept) begin
      unique case (state)
        S_IDLE: begin
          if (mode_i == MODE_BEAT || in_last_i) beats_res = CNT_W'(1);
          else                                  cnt_n     = CNT_W'(1);
        end
        S_ACC: begin
          if (in_last_i) begin
            beats_res = sat_inc(cnt);
            cnt_n     = '0;
          end else begin
            cnt_n = sat_inc(cnt);
          end
        end
        default: cnt_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt         <= '0;
      out_beats_o <= '0;
    end else begin
      cnt <= cnt_n;
      if (emit) out_beats_o <= beats_res;
    end
  end
`endif

endmodule

// File: tb/tb_or_nway_acc.sv
// Directed self-checking bench for or_nway_acc (WIDTH=16, CHANNELS=4, CNT_W=2).
module tb_or_nway_acc;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned CNT_W    = 2;

  logic                      clk;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      in_last;
  logic                      mode;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_any;
`ifdef OR_BEATCNT_EN
  logic [CNT_W-1:0]          out_beats;
`endif

  int unsigned passed = 0;
  int unsigned failed = 0;

  or_nway_acc #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .mode_i      (mode),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_any_o   (out_any)
`ifdef OR_BEATCNT_EN
    ,
    .out_beats_o (out_beats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pk(input logic [15:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_beats(input string tag, input int unsigned exp);
`ifdef OR_BEATCNT_EN
    check(tag, 32'(out_beats), exp);
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d, input logic m, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    in_last  = l;
  endtask

  task automatic idle_in;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
  endtask

  logic [63:0] b2b_in  [3];
  logic [15:0] b2b_exp [3];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_any", 32'(out_any), 0);
    check("rst_ready", 32'(in_ready), 1);
    check_beats("rst_beats", 0);
    rst_n = 1'b1;
    tick();

    // per-beat
    beat(pk(16'h0001, 16'h0010, 16'h0100, 16'h1000), 1'b0, 1'b0);
    tick();
    idle_in();
    check("pb_valid", 32'(out_valid), 1);
    check("pb_data", 32'(out_data), 32'h1111);
    check("pb_any", 32'(out_any), 1);
    check_beats("pb_beats", 1);
    tick();
    check("pb_drain", 32'(out_valid), 0);

    // accumulate
    beat(pk(16'h0001, 0, 0, 0), 1'b1, 1'b0);
    tick();
    check("acc_b1_quiet", 32'(out_valid), 0);
    beat(pk(16'h8000, 0, 0, 0), 1'b1, 1'b0);
    tick();
    check("acc_b2_quiet", 32'(out_valid), 0);
    beat(pk(16'h0F00, 0, 0, 0), 1'b1, 1'b1);
    tick();
    idle_in();
    check("acc_valid", 32'(out_valid), 1);
    check("acc_data", 32'(out_data), 32'h8F01);
    check("acc_any", 32'(out_any), 1);
    check_beats("acc_beats", 3);
    tick();
    check("acc_drain", 32'(out_valid), 0);

    // back-pressure
    out_ready = 1'b0;
    beat(pk(0, 0, 16'h00A0, 0), 1'b0, 1'b0);
    tick();
    check("bp_first_data", 32'(out_data), 32'h00A0);
    beat(pk(0, 16'h0005, 0, 0), 1'b0, 1'b0);
    #1;
    check("bp_ready_low", 32'(in_ready), 0);
    tick();
    check("bp_hold_valid", 32'(out_valid), 1);
    check("bp_hold_data", 32'(out_data), 32'h00A0);
    out_ready = 1'b1;
    #1;
    check("bp_ready_high", 32'(in_ready), 1);
    tick();
    idle_in();
    check("bp_new_valid", 32'(out_valid), 1);
    check("bp_new_data", 32'(out_data), 32'h0005);
    tick();
    check("bp_drain", 32'(out_valid), 0);

    // all-zero beat still emitted
    beat(pk(0, 0, 0, 0), 1'b0, 1'b0);
    tick();
    idle_in();
    check("zero_valid", 32'(out_valid), 1);
    check("zero_data", 32'(out_data), 0);
    check("zero_any", 32'(out_any), 0);
    tick();

    // mode toggled mid-packet is ignored
    beat(pk(0, 0, 0, 16'h0003), 1'b1, 1'b0);
    tick();
    beat(pk(16'h0040, 0, 0, 0), 1'b0, 1'b0);
    tick();
    check("mode_ignored", 32'(out_valid), 0);
    beat(pk(0, 16'h0400, 0, 0), 1'b0, 1'b1);
    tick();
    idle_in();
    check("mode_data", 32'(out_data), 32'h0443);
    check_beats("mode_beats", 3);
    tick();

    // reset mid-packet
    beat(pk(16'h0100, 0, 0, 0), 1'b1, 1'b0);
    tick();
    beat(pk(0, 0, 16'h0020, 0), 1'b1, 1'b0);
    tick();
    idle_in();
    rst_n = 1'b0;
    #2;
    check("midrst_valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    tick();
    beat(pk(16'h0002, 0, 0, 0), 1'b1, 1'b1);
    tick();
    idle_in();
    check("midrst_valid2", 32'(out_valid), 1);
    check("midrst_data", 32'(out_data), 32'h0002);
    check_beats("midrst_beats", 1);
    tick();

    // long packet; beat count saturates at 3 with CNT_W=2
    for (int i = 0; i < 5; i++) begin
      beat(pk(16'(1 << i), 0, 0, 0), 1'b1, (i == 4));
      tick();
    end
    idle_in();
    check("sat_data", 32'(out_data), 32'h001F);
    check_beats("sat_beats", 3);
    tick();

    // back-to-back per-beat stream
    b2b_in[0] = pk(16'h0011, 0, 0, 0);      b2b_exp[0] = 16'h0011;
    b2b_in[1] = pk(0, 16'h0022, 16'h0200, 0); b2b_exp[1] = 16'h0222;
    b2b_in[2] = pk(0, 0, 0, 16'h4004);      b2b_exp[2] = 16'h4004;
    beat(b2b_in[0], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) beat(b2b_in[i+1], 1'b0, 1'b0);
      else idle_in();
      check("b2b_valid", 32'(out_valid), 1);
      check("b2b_data", 32'(out_data), 32'(b2b_exp[i]));
    end
    tick();
    check("b2b_drain", 32'(out_valid), 0);

    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end

endmodule
